// File: rtl/four_bits_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// four_bits_accumulator_pkg
// Shared definitions for the four-bit accumulator and its ripple adder.
//   WIDTH   : data path width of operands, sum and accumulator register
//   CNT_W   : width of the operand counter (covers run lengths 1..15)
//   state_t : accumulator FSM encoding (IDLE / ACCUM / DONE)
// -----------------------------------------------------------------------------
package four_bits_accumulator_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index of the final operand of a run, sized to the counter.
  function automatic logic [CNT_W-1:0] last_index(input int n_ops);
    return CNT_W'(n_ops - 1);
  endfunction

endpackage

// File: rtl/four_bits_adder.sv
// -----------------------------------------------------------------------------
// four_bits_adder
// Purely combinational ripple-carry adder built from WIDTH full-adder cells.
// Ports:
//   i_a, i_b : operands (unsigned or two's complement)
//   i_cin    : carry into bit 0
//   o_s      : WIDTH-bit modulo sum
//   o_c      : carry out of the MSB (unsigned overflow, equals sum bit WIDTH)
//   o_o      : signed overflow, carry into MSB XOR carry out of MSB
// -----------------------------------------------------------------------------
module four_bits_adder
  import four_bits_accumulator_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_o
);

  // w_carry[gi] is the carry into bit gi; w_carry[WIDTH] is the carry-out.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic w_p;
      assign w_p            = i_a[gi] ^ i_b[gi];
      assign o_s[gi]        = w_p ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & w_p);
    end
  endgenerate

  assign o_c = w_carry[WIDTH];
  assign o_o = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule

// File: rtl/four_bits_accumulator.sv
// -----------------------------------------------------------------------------
// four_bits_accumulator
// Adds a stream of N_OPS four-bit operands (valid/ready handshake) into a
// running register, keeping sticky unsigned-carry and signed-overflow flags.
// Completion is flagged by a one-cycle done pulse; the result then holds
// until the next start.
// Parameters:
//   N_OPS        : operands per run, 1..15
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin a new run (only honoured in IDLE)
//   in_valid     : in_data holds an operand
//   in_data      : operand
//   in_ready     : operand accepted this cycle when in_valid is also high
//   acc          : registered running sum
//   carry_sticky : OR of adder carry-out over the run
//   ovf_sticky   : OR of adder signed overflow over the run
//   busy         : high in ACCUM and DONE
//   done         : one-cycle pulse after the final accept
// -----------------------------------------------------------------------------
module four_bits_accumulator
  import four_bits_accumulator_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry_sticky,
  output logic             ovf_sticky,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = last_index(N_OPS);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_carry_sticky;
  logic             w_carry_next;
  logic             r_ovf_sticky;
  logic             w_ovf_next;

  logic [WIDTH-1:0] w_sum;
  logic             w_c;
  logic             w_o;

  // The adder always sees the current register and the offered operand;
  // its result is only committed on an accepted handshake.
  four_bits_adder u_adder (
    .i_a   (r_acc),
    .i_b   (in_data),
    .i_cin (1'b0),
    .o_s   (w_sum),
    .o_c   (w_c),
    .o_o   (w_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_carry_sticky <= 1'b0;
      r_ovf_sticky   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_acc          <= w_acc_next;
      r_count        <= w_count_next;
      r_carry_sticky <= w_carry_next;
      r_ovf_sticky   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_carry_next = r_carry_sticky;
    w_ovf_next   = r_ovf_sticky;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_acc_next   = '0;
          w_count_next = '0;
          w_carry_next = 1'b0;
          w_ovf_next   = 1'b0;
          w_state_next = ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          w_acc_next   = w_sum;
          w_carry_next = r_carry_sticky | w_c;
          w_ovf_next   = r_ovf_sticky | w_o;
          // The counter wraps to zero on the final accept so it never
          // holds a value beyond the last operand index.
          if (r_count == LAST_IDX) begin
            w_count_next = '0;
            w_state_next = DONE;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
      end

      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign acc          = r_acc;
  assign carry_sticky = r_carry_sticky;
  assign ovf_sticky   = r_ovf_sticky;

endmodule

// File: tb/tb_four_bits_accumulator.sv
// -----------------------------------------------------------------------------
// tb_four_bits_accumulator
// Directed-vector bench with a scoreboard: stimulus pushes the expected
// per-accept {acc, carry, ovf} and the expected end-of-run result; a monitor
// pops and compares on every accepted operand and on every done pulse.
// A second instance with N_OPS=1 covers the single-operand run.
// -----------------------------------------------------------------------------
module tb_four_bits_accumulator;

  typedef struct packed {
    logic [3:0] acc;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] acc;
  logic       carry_sticky;
  logic       ovf_sticky;
  logic       busy;
  logic       done;

  logic       start2;
  logic       in_valid2;
  logic [3:0] in_data2;
  logic       in_ready2;
  logic [3:0] acc2;
  logic       carry2;
  logic       ovf2;
  logic       busy2;
  logic       done2;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t acc_q[$];
  exp_t run_q[$];
  int   done_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  four_bits_accumulator #(.N_OPS(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .acc          (acc),
    .carry_sticky (carry_sticky),
    .ovf_sticky   (ovf_sticky),
    .busy         (busy),
    .done         (done)
  );

  four_bits_accumulator #(.N_OPS(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start2),
    .in_valid     (in_valid2),
    .in_data      (in_data2),
    .in_ready     (in_ready2),
    .acc          (acc2),
    .carry_sticky (carry2),
    .ovf_sticky   (ovf2),
    .busy         (busy2),
    .done         (done2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accept is sampled mid-low-phase, its effect checked just after
  // the following rising edge, together with any done pulse.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        if (acc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_accept: acc=%0h with nothing expected (cycle %0d)", acc, cyc);
        end else begin
          e = acc_q.pop_front();
          check("step_acc_c_o", {2'b0, acc, carry_sticky, ovf_sticky}, {2'b0, e.acc, e.c, e.o});
        end
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (run_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: done=1 with no run expected (cycle %0d)", cyc);
        end else begin
          e = run_q.pop_front();
          check("run_result", {2'b0, acc, carry_sticky, ovf_sticky}, {2'b0, e.acc, e.c, e.o});
        end
      end
      @(negedge clk);
      #1;
      pend = rst_n && in_valid && in_ready;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [3:0] d, input logic [3:0] ea, input logic ec, input logic eo);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    acc_q.push_back('{acc: ea, c: ec, o: eo});
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_run(input logic [3:0] ea, input logic ec, input logic eo);
    run_q.push_back('{acc: ea, c: ec, o: eo});
  endtask

  initial begin : stimulus
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    start2    = 1'b0;
    in_valid2 = 1'b0;
    in_data2  = 4'd0;

    // Reset state
    #12;
    check("rst_acc",      {4'b0, acc}, 8'd0);
    check("rst_flags",    {6'b0, carry_sticky, ovf_sticky}, 8'd0);
    check("rst_ctrl",     {5'b0, busy, done, in_ready}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: 1,1,1,1
    pulse_start();
    #1;
    check("accum_ready_busy", {6'b0, in_ready, busy}, 8'h03);
    expect_run(4'd4, 1'b0, 1'b0);
    send(4'd1, 4'd1, 1'b0, 1'b0);
    send(4'd1, 4'd2, 1'b0, 1'b0);
    send(4'd1, 4'd3, 1'b0, 1'b0);
    send(4'd1, 4'd4, 1'b0, 1'b0);
    bubble();
    #1;
    check("done_state", {5'b0, done, busy, in_ready}, 8'h06);
    bubble();
    #1;
    check("idle_after_done", {5'b0, done, busy, in_ready}, 8'h00);
    check("idle_hold_acc", {4'b0, acc}, 8'd4);

    // Flags: 3,4,5,6
    pulse_start();
    expect_run(4'd2, 1'b1, 1'b1);
    send(4'd3, 4'd3,  1'b0, 1'b0);
    send(4'd4, 4'd7,  1'b0, 1'b0);
    send(4'd5, 4'd12, 1'b0, 1'b1);
    send(4'd6, 4'd2,  1'b1, 1'b1);
    bubble();
    bubble();

    // Bubbles: 2,_,_,3,_,1,4
    pulse_start();
    expect_run(4'd10, 1'b0, 1'b1);
    send(4'd2, 4'd2, 1'b0, 1'b0);
    bubble();
    #1;
    check("ready_in_bubble", {7'b0, in_ready}, 8'd1);
    bubble();
    send(4'd3, 4'd5, 1'b0, 1'b0);
    bubble();
    #1;
    check("ready_in_bubble2", {7'b0, in_ready}, 8'd1);
    send(4'd1, 4'd6,  1'b0, 1'b0);
    send(4'd4, 4'd10, 1'b0, 1'b1);
    bubble();
    bubble();

    // Ignored start mid-run, blocked input in DONE and IDLE
    pulse_start();
    expect_run(4'd2, 1'b1, 1'b1);
    send(4'd8, 4'd8, 1'b0, 1'b0);
    send(4'd8, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    send(4'd1, 4'd1, 1'b1, 1'b1);
    send(4'd1, 4'd2, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd5;
    #1;
    check("done_blocks_input", {6'b0, done, in_ready}, 8'h02);
    @(negedge clk);
    #1;
    check("idle_blocks_input", {7'b0, in_ready}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("blocked_acc_hold", {4'b0, acc}, 8'd2);

    // Asynchronous reset mid-run after two accepts
    pulse_start();
    send(4'd3, 4'd3, 1'b0, 1'b0);
    send(4'd4, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_acc", {4'b0, acc}, 8'd0);
    check("async_rst_ctrl", {4'b0, busy, done, in_ready, 1'b0}, 8'd0);
    check("async_rst_flags", {6'b0, carry_sticky, ovf_sticky}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bubble();
    #1;
    check("post_rst_idle", {6'b0, busy, done}, 8'd0);
    pulse_start();
    expect_run(4'd10, 1'b0, 1'b1);
    send(4'd1, 4'd1,  1'b0, 1'b0);
    send(4'd2, 4'd3,  1'b0, 1'b0);
    send(4'd3, 4'd6,  1'b0, 1'b0);
    send(4'd4, 4'd10, 1'b0, 1'b1);
    bubble();
    bubble();

    // Back-to-back with start held high; flags must clear at the second start
    @(negedge clk);
    start = 1'b1;
    expect_run(4'd0, 1'b1, 1'b1);
    expect_run(4'd4, 1'b0, 1'b0);
    send(4'd8, 4'd8, 1'b0, 1'b0);
    send(4'd8, 4'd0, 1'b1, 1'b1);
    send(4'd8, 4'd8, 1'b1, 1'b1);
    send(4'd8, 4'd0, 1'b1, 1'b1);
    bubble();
    bubble();
    send(4'd1, 4'd1, 1'b0, 1'b0);
    send(4'd1, 4'd2, 1'b0, 1'b0);
    send(4'd1, 4'd3, 1'b0, 1'b0);
    send(4'd1, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    bubble();
    n_tests++;
    if (done_cyc.size() < 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: only %0d done pulses seen, required at least 2", done_cyc.size());
    end else if (done_cyc[$] - done_cyc[$-1] != 6) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: done spacing %0d cycles, required 6", done_cyc[$] - done_cyc[$-1]);
    end

    // N_OPS=1 instance, operand 15
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2    = 1'b0;
    in_valid2 = 1'b1;
    in_data2  = 4'd15;
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("n1_done", {6'b0, done2, busy2}, 8'h03);
    check("n1_result", {2'b0, acc2, carry2, ovf2}, {2'b0, 4'd15, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    check("n1_idle", {6'b0, done2, busy2}, 8'h00);
    check("n1_hold", {4'b0, acc2}, 8'd15);

    // Scoreboard drained
    @(negedge clk);
    check("acc_q_empty", 8'(acc_q.size()), 8'd0);
    check("run_q_empty", 8'(run_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/four_bits_accumulator.md
Name: four_bits_accumulator

Overview:
Sequential accumulator that sits directly downstream of the four-bit ripple adder and feeds it on every cycle. It adds a stream of 4-bit operands, delivered over a valid/ready handshake, into a running 4-bit register. It records sticky unsigned-carry and signed-overflow flags taken from the adder's c and o outputs. After N_OPS operands it signals completion and holds the result until the next start.

Parameters:
N_OPS, 4, number of operands per accumulation run; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new run; sampled only in IDLE
in_valid  input  1  in_data carries a valid operand this cycle
in_data  input  4  unsigned / two's-complement operand
in_ready  output  1  block accepts an operand this cycle
acc  output  4  running sum, registered
carry_sticky  output  1  OR of adder carry-out over the run
ovf_sticky  output  1  OR of adder signed overflow over the run
busy  output  1  high in ACCUM and DONE
done  output  1  single-cycle pulse when the run completes

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0, count=0, carry_sticky=0, ovf_sticky=0, done=0, busy=0, in_ready=0.
- Handshake: an operand is accepted on a rising edge only when in_valid=1 and in_ready=1.
  - in_ready is a combinational decode of state: 1 only in ACCUM.
  - in_valid with in_ready=0 is ignored; the operand is not queued.
- FSM states:
  - IDLE: in_ready=0, busy=0. If start=1, then on the next edge: acc<=0, count<=0, carry_sticky<=0, ovf_sticky<=0, state<=ACCUM. Otherwise all registers hold, so the previous result stays visible.
  - ACCUM: in_ready=1, busy=1. On accept:
    - acc <= adder s[3:0] of (acc + in_data), with a carry-in of 0.
    - carry_sticky |= c; ovf_sticky |= o, where o = cout3 XOR cout2 (signed overflow of that step).
    - count <= count+1.
    - If the accept is the N_OPS-th one (count==N_OPS-1), state<=DONE.
    - Cycles without in_valid (bubbles) change nothing.
  - DONE: in_ready=0, busy=1, done=1 for exactly this one cycle; next edge state<=IDLE. acc and the flags hold.
- Latency: acc reflects an operand on the edge that accepts it. done is high in the cycle immediately after the final accept.
- Arithmetic: 4-bit modulo-16 wrap; bit 4 of the adder sum equals c and is not stored separately.
- start while in ACCUM or DONE is ignored; there is no restart mid-run.
- start held high continuously: a new run begins on the first IDLE cycle, giving back-to-back runs with one IDLE cycle between them.
- Reset mid-run: immediate return to IDLE with all registers cleared; no done pulse.
- N_OPS=1: a single accept goes straight to DONE.
- count is 4 bits and never exceeds N_OPS-1.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, ACCUM=2'd1, DONE=2'd2, and data width constant WIDTH=4.
- One sub-module: an instance of the existing four_bits_adder.
  - a = acc register, b = in_data.
  - Its c and o drive the sticky-flag update logic.
  - The adder itself stays combinational; all state lives in the accumulator.

Test Plan:
- Basic run, N_OPS=4: start, then operands 1,1,1,1 with in_valid held high -> acc steps 1,2,3,4; done pulses one cycle after the 4th accept; carry_sticky=0, ovf_sticky=0; then IDLE with acc=4 held.
- Flags, N_OPS=4: operands 3,4,5,6 -> acc steps 3,7,12(4'b1100),2. ovf_sticky goes to 1 on the 7+5 step; carry_sticky goes to 1 on the 12+6 step; final acc=2, both flags 1.
- Bubbles: operands 2,_,_,3,_,1,4 with gaps in in_valid -> only 4 accepts counted; acc=10; done the cycle after the accept of 4; in_ready stays 1 throughout ACCUM.
- Ignored start and blocked input: pulse start during ACCUM after 2 accepts -> no clear, run completes normally. in_valid=1 in IDLE and DONE -> acc unchanged.
- Reset mid-run: assert rst_n=0 asynchronously between edges after 2 accepts -> outputs go to 0 immediately without waiting for an edge; no done pulse; after release, start begins a fresh run from acc=0.
- Back-to-back and N_OPS=1: start held high -> done pulses separated by the DONE+IDLE gap, and flags clear at each new start. Rebuild with N_OPS=1 and operand 15 -> acc=15, done the next cycle.
